// File: rtl/ddr_rd_pkg.sv
// ============================================================================
// ddr_rd_pkg : shared types and helpers for the DDR read-burst feeder
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package ddr_rd_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_SPACE = 3'd1,
    ADDR       = 3'd2,
    DATA       = 3'd3,
    DONE       = 3'd4
  } state_e;

  localparam int AXI_LEN_W = 8;

  function automatic int unsigned bytes_per_burst(input int unsigned burst_len,
                                                  input int unsigned data_width);
    return (burst_len * data_width) / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ddr_rd_beat_chk.sv
// ============================================================================
// ddr_rd_beat_chk : per-burst beat counter and sticky rlast validator
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_rd_beat_chk
  import ddr_rd_pkg::*;
#(
  parameter int BURST_LEN = 16
) (
  input  logic clk,
  input  logic tb_rst,
  input  logic clr,
  input  logic beat,
  input  logic rlast,
  output logic last_beat,
  output logic err
);

  localparam logic [AXI_LEN_W-1:0] LAST_IDX = AXI_LEN_W'(BURST_LEN - 1);

  logic [AXI_LEN_W-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;

  assign last_beat = (cnt_q == LAST_IDX);
  assign err       = err_q;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (clr) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (beat) begin
      cnt_d = last_beat ? '0 : cnt_q + 1'b1;
      // rlast must coincide exactly with the counted final beat
      if (rlast != last_beat) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ddr_rd_burst_ctrl.sv
// ============================================================================
// ddr_rd_burst_ctrl : issues fixed-length AXI read bursts into read_ddr_fifo
// Optional stall counter built when DDR_RD_PERF_CNT_EN is defined.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_rd_burst_ctrl
  import ddr_rd_pkg::*;
#(
  parameter int ADDR_WIDTH       = 28,
  parameter int DATA_WIDTH       = 256,
  parameter int BURST_LEN        = 16,
  parameter int FIFO_DEPTH_WIDTH = 10,
  parameter int FIFO_MARGIN      = 4
) (
  input  logic                      clk,
  input  logic                      tb_rst,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [15:0]               burst_cnt,
  output logic                      busy,
  output logic                      done,
  output logic                      err_rlast,
  output logic [ADDR_WIDTH-1:0]     axi_araddr,
  output logic [AXI_LEN_W-1:0]      axi_arlen,
  output logic                      axi_arvalid,
  input  logic                      axi_arready,
  input  logic [DATA_WIDTH-1:0]     axi_rdata,
  input  logic                      axi_rvalid,
  input  logic                      axi_rlast,
  output logic                      axi_rready,
  output logic [DATA_WIDTH-1:0]     fifo_wr_data,
  output logic                      fifo_wr_en,
  input  logic [FIFO_DEPTH_WIDTH:0] fifo_wr_water_level,
  output logic [31:0]               perf_stall_cycles
);

  localparam int unsigned           BYTES    = bytes_per_burst(BURST_LEN, DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_INC = ADDR_WIDTH'(BYTES);
  localparam int                    LVL_W    = FIFO_DEPTH_WIDTH + 2;
  localparam logic [LVL_W-1:0]      SPACE_THRESH =
    LVL_W'((2 ** FIFO_DEPTH_WIDTH) - BURST_LEN - FIFO_MARGIN);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [15:0]             remain_q, remain_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    wr_en_q, wr_en_d;

  logic start_acc;
  logic beat;
  logic last_beat;
  logic space_ok;

  assign start_acc = start && (state_q == IDLE);
  assign beat      = axi_rvalid && axi_rready;
  assign space_ok  = ({1'b0, fifo_wr_water_level} <= SPACE_THRESH);

  assign busy         = busy_q;
  assign done         = done_q;
  assign axi_araddr   = addr_q;
  assign axi_arlen    = AXI_LEN_W'(BURST_LEN - 1);
  assign axi_arvalid  = (state_q == ADDR);
  assign axi_rready   = (state_q == DATA);
  assign fifo_wr_data = wr_data_q;
  assign fifo_wr_en   = wr_en_q;

  ddr_rd_beat_chk #(
    .BURST_LEN (BURST_LEN)
  ) u_beat_chk (
    .clk       (clk),
    .tb_rst    (tb_rst),
    .clr       (start_acc),
    .beat      (beat),
    .rlast     (axi_rlast),
    .last_beat (last_beat),
    .err       (err_rlast)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wr_en_d   = beat;
    wr_data_d = beat ? axi_rdata : wr_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          remain_d = burst_cnt;
          busy_d   = 1'b1;
          state_d  = (burst_cnt == 16'd0) ? DONE : WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        if (space_ok) begin
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (axi_arready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (beat && last_beat) begin
          addr_d   = addr_q + ADDR_INC;
          remain_d = remain_q - 16'd1;
          state_d  = (remain_q == 16'd1) ? DONE : WAIT_SPACE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
    end
  end

`ifdef DDR_RD_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  // Saturating count of cycles spent waiting for FIFO room
  always_comb begin
    perf_d = perf_q;
    if (start_acc) begin
      perf_d = '0;
    end else if ((state_q == WAIT_SPACE) && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cycles = perf_q;
`else
  assign perf_stall_cycles = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ddr_rd_burst_ctrl.sv
// ============================================================================
// tb_ddr_rd_burst_ctrl : directed stimulus with queue scoreboard for ddr_rd_burst_ctrl
// Rev 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ddr_rd_burst_ctrl;

  localparam int BL = 16;

  logic         clk = 1'b0;
  logic         tb_rst;
  logic         start;
  logic [27:0]  base_addr;
  logic [15:0]  burst_cnt;
  logic         busy, done, err_rlast;
  logic [27:0]  axi_araddr;
  logic [7:0]   axi_arlen;
  logic         axi_arvalid, axi_arready;
  logic [255:0] axi_rdata;
  logic         axi_rvalid, axi_rlast, axi_rready;
  logic [255:0] fifo_wr_data;
  logic         fifo_wr_en;
  logic [10:0]  fifo_wr_water_level;
  logic [31:0]  perf_stall_cycles;

  int n_vec  = 0;
  int n_miss = 0;
  int unsigned seq = 0;

  logic [27:0]  exp_ar[$];
  logic [255:0] exp_wr[$];

  always #5 clk = ~clk;

  ddr_rd_burst_ctrl dut (
    .clk                 (clk),
    .tb_rst              (tb_rst),
    .start               (start),
    .base_addr           (base_addr),
    .burst_cnt           (burst_cnt),
    .busy                (busy),
    .done                (done),
    .err_rlast           (err_rlast),
    .axi_araddr          (axi_araddr),
    .axi_arlen           (axi_arlen),
    .axi_arvalid         (axi_arvalid),
    .axi_arready         (axi_arready),
    .axi_rdata           (axi_rdata),
    .axi_rvalid          (axi_rvalid),
    .axi_rlast           (axi_rlast),
    .axi_rready          (axi_rready),
    .fifo_wr_data        (fifo_wr_data),
    .fifo_wr_en          (fifo_wr_en),
    .fifo_wr_water_level (fifo_wr_water_level),
    .perf_stall_cycles   (perf_stall_cycles)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] mk(input int unsigned s);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = s ^ (32'(i) * 32'h0101_0101);
    return r;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents an AR handshake or a FIFO write
  always @(negedge clk) begin
    if (!tb_rst) begin
      if (axi_arvalid && axi_arready) begin
        if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
        else begin
          chk("araddr", axi_araddr, exp_ar.pop_front());
          chk("arlen", axi_arlen, 8'd15);
        end
      end
      if (fifo_wr_en) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
        else chk("fifo_wr_data", fifo_wr_data, exp_wr.pop_front());
      end
    end
  end

  task automatic do_start(input logic [27:0] a, input logic [15:0] n);
    base_addr = a;
    burst_cnt = n;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = 28'hABCDEF0;
    burst_cnt = 16'd7;
    chk("busy_after_start", busy, 1);
    chk("err_cleared_by_start", err_rlast, 0);
  endtask

  // One AXI read burst from the slave side; abort_beat >= 0 asserts tb_rst after that beat
  task automatic serve(input logic [27:0] ea, input int ar_dly, input int bad_beat,
                       input bit omit_last, input int abort_beat);
    int t = 0;
    exp_ar.push_back(ea);
    while (!axi_arvalid && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("arvalid_seen", axi_arvalid, 1);
    for (int d = 0; d < ar_dly; d++) begin
      @(posedge clk); #1;
      chk("ar_stall_valid", axi_arvalid, 1);
      chk("ar_stall_addr", axi_araddr, ea);
    end
    axi_arready = 1'b1;
    @(posedge clk); #1;
    axi_arready = 1'b0;
    chk("rready_in_data", axi_rready, 1);
    chk("no_arvalid_in_data", axi_arvalid, 0);
    for (int b = 0; b < BL; b++) begin
      axi_rvalid = 1'b1;
      axi_rdata  = mk(seq);
      axi_rlast  = ((b == BL - 1) && !omit_last) || (b == bad_beat);
      if (abort_beat < 0 || b < abort_beat) exp_wr.push_back(mk(seq));
      seq++;
      @(posedge clk); #1;
      if (b == abort_beat) begin
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        tb_rst     = 1'b1;
        return;
      end
    end
    axi_rvalid = 1'b0;
    axi_rlast  = 1'b0;
  endtask

  task automatic wait_done(input logic exp_err);
    int t = 0;
    while (!done && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("done_seen", done, 1);
    chk("busy_low_at_done", busy, 0);
    chk("err_rlast_at_done", err_rlast, exp_err);
    chk("wr_queue_drained", exp_wr.size(), 0);
    @(posedge clk); #1;
    chk("done_single_pulse", done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tb_rst = 1'b1;
    start = 1'b0; base_addr = '0; burst_cnt = '0;
    axi_arready = 1'b0; axi_rdata = '0; axi_rvalid = 1'b0; axi_rlast = 1'b0;
    fifo_wr_water_level = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_arvalid", axi_arvalid, 0);
    chk("rst_rready", axi_rready, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_araddr", axi_araddr, 0);
    chk("rst_perf", perf_stall_cycles, 0);
    tb_rst = 1'b0;
    @(posedge clk); #1;

    // Nominal three-burst frame, with a stray start that must be ignored
    do_start(28'h0000100, 16'd3);
    serve(28'h0000100, 0, -1, 1'b0, -1);
    base_addr = 28'h7777770; burst_cnt = 16'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    serve(28'h0000300, 0, -1, 1'b0, -1);
    serve(28'h0000500, 0, -1, 1'b0, -1);
    wait_done(1'b0);

    // Backpressure: 1005 holds off, 1004 (threshold) releases
    fifo_wr_water_level = 11'd1005;
    do_start(28'h0008000, 16'd1);
    for (int i = 0; i < 6; i++) begin
      chk("bp_no_arvalid", axi_arvalid, 0);
      @(posedge clk); #1;
    end
    fifo_wr_water_level = 11'd1004;
    chk("bp_no_arvalid_last", axi_arvalid, 0);
    @(posedge clk); #1;
    chk("bp_arvalid_after_release", axi_arvalid, 1);
    serve(28'h0008000, 0, -1, 1'b0, -1);
    fifo_wr_water_level = '0;
    wait_done(1'b0);
`ifdef DDR_RD_PERF_CNT_EN
    // WAIT_SPACE occupied from the start edge through the release edge: 7 cycles
    chk("perf_stall_cycles", perf_stall_cycles, 32'd7);
`else
    chk("perf_stall_cycles_tied", perf_stall_cycles, 32'd0);
`endif

    // Zero-length frame
    do_start(28'h0000123, 16'd0);
    chk("zl_done_early", done, 0);
    chk("zl_no_arvalid", axi_arvalid, 0);
    @(posedge clk); #1;
    chk("zl_done", done, 1);
    chk("zl_busy_dropped", busy, 0);
    chk("zl_no_arvalid2", axi_arvalid, 0);
    @(posedge clk); #1;
    chk("zl_done_pulse", done, 0);

    // rlast errors, then cleared by the next start
    do_start(28'h0001000, 16'd1);
    serve(28'h0001000, 0, 7, 1'b0, -1);
    wait_done(1'b1);
    do_start(28'h0002000, 16'd1);
    serve(28'h0002000, 0, -1, 1'b1, -1);
    wait_done(1'b1);
    do_start(28'h0003000, 16'd1);
    serve(28'h0003000, 0, -1, 1'b0, -1);
    wait_done(1'b0);

    // Address wrap with a 5-cycle arready stall on the first burst
    do_start(28'hFFFFE00, 16'd2);
    serve(28'hFFFFE00, 5, -1, 1'b0, -1);
    serve(28'h0000000, 0, -1, 1'b0, -1);
    wait_done(1'b0);

    // Reset after beat 4 of the first burst
    do_start(28'h0002000, 16'd2);
    serve(28'h0002000, 0, -1, 1'b0, 4);
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr_en", fifo_wr_en, 0);
    chk("mid_rst_wr_data", fifo_wr_data, 0);
    chk("mid_rst_rready", axi_rready, 0);
    chk("mid_rst_araddr", axi_araddr, 0);
    chk("mid_rst_arvalid", axi_arvalid, 0);
    chk("mid_rst_perf", perf_stall_cycles, 0);
    chk("mid_rst_wr_queue", exp_wr.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    tb_rst = 1'b0;
    @(posedge clk); #1;
    do_start(28'h0000040, 16'd1);
    serve(28'h0000040, 0, -1, 1'b0, -1);
    wait_done(1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("ar_queue_empty", exp_ar.size(), 0);
    chk("wr_queue_empty", exp_wr.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ddr_rd_burst_ctrl.md
Name: ddr_rd_burst_ctrl

Overview:
- Upstream feeder of the 256-to-32-bit read_ddr_fifo.
- On a start pulse, issues a sequence of fixed-length AXI read bursts to the DDR3 controller and forwards returned 256-bit beats into the FIFO write port.
- Holds off each burst until the FIFO water level guarantees room for the whole burst, so rready never deasserts mid-burst.
- Runs entirely in the FIFO write clock domain (clk).

Parameters:
- ADDR_WIDTH, 28, AXI byte-address width.
- DATA_WIDTH, 256, AXI rdata / FIFO wr_data width.
- BURST_LEN, 16, beats per burst (1..256).
- FIFO_DEPTH_WIDTH, 10, FIFO write-side depth log2; water level is FIFO_DEPTH_WIDTH+1 bits.
- FIFO_MARGIN, 4, extra free entries required beyond BURST_LEN (covers write pipeline and water-level latency).

Ports:
- clk  in  1  clock; also FIFO wr_clk.
- tb_rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame; ignored while busy.
- base_addr  in  ADDR_WIDTH  first burst byte address; sampled on start.
- burst_cnt  in  16  number of bursts in the frame; sampled on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the frame completes.
- err_rlast  out  1  sticky rlast-protocol error; cleared only by tb_rst or an accepted start.
- axi_araddr  out  ADDR_WIDTH  burst address.
- axi_arlen  out  8  constant BURST_LEN-1.
- axi_arvalid  out  1  address valid.
- axi_arready  in  1  address ready.
- axi_rdata  in  DATA_WIDTH  read data.
- axi_rvalid  in  1  read valid.
- axi_rlast  in  1  last beat.
- axi_rready  out  1  read ready.
- fifo_wr_data  out  DATA_WIDTH  to FIFO wr_data.
- fifo_wr_en  out  1  to FIFO wr_en.
- fifo_wr_water_level  in  FIFO_DEPTH_WIDTH+1  from FIFO wr_water_level.
- perf_stall_cycles  out  32  see Optional Feature.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal address and counters 0.
- IDLE:
  - On start, latch base_addr and burst_cnt, clear err_rlast, set busy next cycle.
  - If burst_cnt==0, go to DONE; otherwise go to WAIT_SPACE.
- WAIT_SPACE:
  - Advance to ADDR when fifo_wr_water_level <= 2**FIFO_DEPTH_WIDTH - BURST_LEN - FIFO_MARGIN.
  - The compare is unsigned, at FIFO_DEPTH_WIDTH+2 bits.
- ADDR:
  - Assert axi_arvalid with axi_araddr = current address.
  - Hold both stable until axi_arready; that cycle is the handshake, then go to DATA.
  - arvalid never drops without a handshake.
- DATA:
  - axi_rready=1 throughout.
  - Each rvalid&rready beat is registered onto fifo_wr_data and fifo_wr_en on the next clk edge, giving 1-cycle latency.
  - fifo_wr_en is high for exactly one cycle per beat.
  - The beat counter counts 0..BURST_LEN-1; the burst ends on the beat where count==BURST_LEN-1.
- End of burst:
  - Address += BURST_LEN*DATA_WIDTH/8, wrapping modulo 2**ADDR_WIDTH.
  - Remaining-burst count decrements.
  - If bursts remain, go to WAIT_SPACE; otherwise go to DONE.
- rlast checking:
  - rlast on a beat other than the final beat sets err_rlast; the burst still runs to the counted length.
  - rlast absent on the final beat also sets err_rlast.
- DONE: pulse done for 1 cycle, drop busy in the same cycle, return to IDLE.
- Only one burst is outstanding at a time. arvalid is never asserted in DATA.
- start while busy is ignored and does not re-sample inputs.
- rvalid outside DATA is a protocol violation: rready=0 there, no FIFO write occurs.
- tb_rst mid-frame:
  - Immediate return to IDLE, outputs to reset values.
  - The in-flight registered FIFO write is dropped.
  - The FIFO is reset by the same tb_rst.
- Simultaneous arready and the state's first arvalid cycle is legal: a 1-cycle ADDR state.

Optional Feature:
- Macro DDR_RD_PERF_CNT_EN.
- Defined: perf_stall_cycles counts cycles spent in WAIT_SPACE. It clears on an accepted start, saturates at 0xFFFFFFFF, and holds after done.
- Undefined: counter logic is not built and perf_stall_cycles is tied to 0.

Decomposition:
- Package ddr_rd_pkg holds:
  - the state enum (IDLE, WAIT_SPACE, ADDR, DATA, DONE);
  - AXI_LEN_W=8;
  - function bytes_per_burst(BURST_LEN, DATA_WIDTH).
- One sub-module, ddr_rd_beat_chk, holds the beat counter plus the rlast validator.
  - Inputs: clk, tb_rst, clr, beat, rlast.
  - Outputs: last_beat, err.

Test Plan:
- Nominal frame: start, base_addr=0x0000100, burst_cnt=3, level 0, arready immediate, rvalid continuous.
  - Expect araddr 0x100, 0x300, 0x500 and arlen=15.
  - Expect 48 fifo_wr_en pulses with data equal to rdata delayed 1 cycle.
  - Expect a single done pulse and err_rlast=0.
- Backpressure: water_level held at 1005 (threshold 1004).
  - Expect no arvalid until the level drops to 1004, then arvalid on the next cycle.
  - With DDR_RD_PERF_CNT_EN defined, perf_stall_cycles equals the hold duration.
- Zero-length frame: start with burst_cnt=0.
  - Expect no arvalid, done 2 cycles after start, busy high for exactly 1 cycle.
- rlast errors:
  - rlast on beat 7 of 16 → err_rlast=1, still 16 FIFO writes.
  - Missing rlast on beat 15 → err_rlast=1.
  - err_rlast is cleared by the next accepted start.
- Address wrap and arready stall:
  - base_addr=0xFFFFE00, burst_cnt=2 → second araddr 0x0000000.
  - arready withheld 5 cycles → araddr and arvalid stable throughout.
- Reset mid-burst: assert tb_rst after beat 4.
  - Expect all outputs 0 immediately.
  - After release and a new start, the frame completes correctly.
